// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver state encoding, baud-rate select codes,
// default oversampling ratio and the source clock frequency the baud
// generator divides from.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic [1:0] BAUD_SEL_9600   = 2'b01;
    localparam logic [1:0] BAUD_SEL_57600  = 2'b10;
    localparam logic [1:0] BAUD_SEL_115200 = 2'b11;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned SOURCE_CLK         = 50_000_000;

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous input. Both flops load
// RESET_VAL on reset so an idle-high line does not look like an edge.
//   clock  : destination clock
//   reset  : asynchronous, active-high
//   d      : asynchronous input
//   q      : synchronised output
// -----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
// Oversampling UART receiver (start, DATA_BITS data LSB first, stop). All
// state advances only on sample_tick; the line is sampled mid-bit.
// Optional even parity bit between data and stop: define UART_RX_PARITY_EN.
//   clock         : system clock
//   reset         : asynchronous, active-high
//   sample_tick   : enable pulse, OVERSAMPLE per bit time
//   rx            : asynchronous serial input, idle high
//   data_out      : last correctly framed byte
//   data_valid    : one-clock pulse when data_out updates
//   framing_error : one-clock pulse when the stop bit samples low
//   parity_error  : one-clock pulse on parity mismatch (0 without parity)
//   busy          : high while a frame is being received
// -----------------------------------------------------------------------------
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 last_sample_q, last_sample_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 framing_error_q, framing_error_d;
    logic                 busy_q, busy_d;
    logic                 frame_ok;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_q, parity_bit_d;
    logic                 parity_error_q, parity_error_d;
`endif

    always_comb begin
        state_d         = state_q;
        tick_cnt_d      = tick_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        last_sample_d   = last_sample_q;
        data_out_d      = data_out_q;
        data_valid_d    = 1'b0;
        framing_error_d = 1'b0;
        frame_ok        = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d    = parity_bit_q;
        parity_error_d  = 1'b0;
`endif

        if (sample_tick) begin
            // Updated on every tick, in every state, so a line that stays low
            // after a frame never looks like a fresh falling edge.
            last_sample_d = rx_s;

            case (state_q)
                IDLE: begin
                    if (last_sample_q && !rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end

                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = PARITY;
`else
                            state_d   = STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        parity_bit_d = rx_s;
                        state_d      = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d      = '0;
                        state_d         = IDLE;
                        framing_error_d = !rx_s;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data bits plus parity bit XOR to 0.
                        parity_error_d  = ^{shift_q, parity_bit_q};
                        frame_ok        = rx_s && !parity_error_d;
`else
                        frame_ok        = rx_s;
`endif
                        if (frame_ok) begin
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            tick_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            last_sample_q   <= 1'b1;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            busy_q          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q    <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            last_sample_q   <= last_sample_d;
            data_out_q      <= data_out_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            busy_q          <= busy_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q    <= parity_bit_d;
            parity_error_q  <= parity_error_d;
`endif
        end
    end

    assign data_out      = data_out_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign busy          = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Serial UART receiver that consumes the per-bit-fraction enable tick produced by the baud generator. The rx line is synchronised and sampled at OVERSAMPLE ticks per bit. The receiver decodes 8N1 frames, LSB first, and presents each byte with a one-cycle valid strobe. It sits between the pad-side rx pin and the byte-level consumer logic.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
OVERSAMPLE, 16, sample_tick pulses per bit period (even, >=4)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
sample_tick  input  1  one-clock enable pulse, OVERSAMPLE per bit time, from baud generator
rx  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  last correctly framed byte
data_valid  output  1  one-clock pulse when data_out updates
framing_error  output  1  one-clock pulse when the stop bit samples low
parity_error  output  1  one-clock pulse on parity mismatch (see Optional Feature)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, active-high): state IDLE, counters 0, shift register 0, data_out 0, data_valid/framing_error/parity_error/busy 0, synchroniser flops and last-sample register preset to 1.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
- All state, counter and sampling actions occur only on clocks where sample_tick=1. Without ticks, everything holds. Strobe outputs are cleared on every clock in which they are not set.
- IDLE: on a tick, if the previous tick's sample was 1 and rx_s=0 (falling edge), go to START with tick_cnt=0. A line held low (break) never retriggers.
- START: tick_cnt increments per tick. At tick_cnt==OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: false start; return to IDLE, no strobes.
- DATA: at tick_cnt==OVERSAMPLE-1, sample rx_s into shift_reg MSB and shift right (LSB first), tick_cnt=0, bit_cnt+1. After DATA_BITS samples, go to STOP, or to PARITY if the feature is enabled.
- STOP: at tick_cnt==OVERSAMPLE-1:
  - rx_s=1: data_out<=shift_reg, data_valid=1 on the next clock.
  - rx_s=0: framing_error=1; data_out holds its previous value.
  - Either way, go to IDLE.
- Latency: strobes assert on the clock edge following the tick that samples mid-stop-bit.
- Back-to-back frames: a start edge can be detected on the first tick after returning to IDLE.
- Reset mid-frame: immediate abort; no strobe is emitted.
- Counter widths: tick_cnt is clog2(OVERSAMPLE) bits; bit_cnt is clog2(DATA_BITS+1) bits. No wrap occurs because each counter is cleared at its terminal value.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP and sampled mid-bit (even parity). If the XOR of the data bits and the parity bit is 1, parity_error pulses together with the stop-bit decision, and data_valid is suppressed for that frame. framing_error still reports independently.
- Undefined: no PARITY state exists, frames are 8N1, and parity_error is tied 0.

Decomposition:
- Shared package uart_pkg contains:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - baudrate_sel codes (2'b01=9600, 2'b10=57600, 2'b11=115200)
  - default OVERSAMPLE
  - SOURCE_CLK constant
- Natural sub-module: uart_sync2, a 2-flop synchroniser with a reset preset value parameter. It is reusable for other async inputs.

Test Plan:
Setup for all scenarios: OVERSAMPLE=16, sample_tick every 4 clocks, UART_RX_PARITY_EN undefined unless stated.
- Clean frame: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> single data_valid pulse, data_out=0xA5, framing_error=0, busy low afterwards.
- False start: rx low for 5 ticks then high -> returns to IDLE, no data_valid or framing_error, data_out unchanged.
- Framing error: send 0x3C with stop bit 0, then release rx high -> framing_error pulses once, data_valid=0, data_out keeps prior 0xA5. The held-low line does not retrigger until a fresh 1->0 edge.
- Back-to-back: 0x00 then 0xFF with exactly one stop bit between -> two data_valid pulses 160 ticks apart, data_out 0x00 then 0xFF.
- Reset mid-frame: assert reset during bit 4 of 0x55 -> outputs 0 immediately. Then send 0x81 -> data_out=0x81, exactly one data_valid pulse.
- With UART_RX_PARITY_EN: send 0x03 with parity bit 1 -> parity_error pulse, data_valid=0. Send 0x03 with parity bit 0 -> data_valid, data_out=0x03.
